pwm_bank: RTL and testbench
===========================

Name: pwm_bank

Overview:
- Parametrised multi-channel PWM generator for the tt_um_gusharov top. Successor to the single-channel PWM behind the SPI register map.
- One shared prescaler and one shared period counter drive NUM_CH compare channels.
- Configuration is written through a simple write strobe, normally from the SPI peripheral's register file.
- All configuration is double-buffered: shadow registers load into active registers only at a period boundary, so no output ever shows a glitched or truncated pulse.

Parameters:
- NUM_CH, 8, number of PWM channels. Legal range is 1..CNT_W; elaboration fails otherwise.
- CNT_W, 8, width of the period counter, duty values, prescale value and write data.
- ADDR_W, $clog2(NUM_CH+3), width of the write address (derived; do not override).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable. Low freezes the counters and forces all outputs to 0.
- wr_en  in  1  single-cycle write strobe
- wr_addr  in  ADDR_W  register select
- wr_data  in  CNT_W  write data
- pwm_out  out  NUM_CH  registered PWM outputs
- period_tick  out  1  one-cycle pulse at each period wrap (active load)
- cnt_out  out  CNT_W  current period counter value, for debug

Behaviour:
- Reset (asynchronous, rst_n=0), all values take effect immediately:
  - shadow and active duties = 0
  - period = {CNT_W{1}}
  - enable mask = 0
  - prescale = 0
  - prescaler count = 0, cnt = 0
  - pwm_out = 0, period_tick = 0
- Register map, written on clk when wr_en=1:
  - addr 0..NUM_CH-1: duty shadow of that channel
  - addr NUM_CH: period shadow
  - addr NUM_CH+1: enable-mask shadow (low NUM_CH bits of wr_data)
  - addr NUM_CH+2: prescale shadow
  - Writes to other addresses are ignored with no side effects.
  - Writes are accepted regardless of ena.
- Prescaler:
  - psc counts 0..prescale_active. tick=1 when psc==prescale_active; psc then returns to 0.
  - prescale_active=0 gives tick every cycle.
- Period counter:
  - On tick, if cnt==period_active, then cnt<=0, active<=shadow (all fields together), and period_tick<=1 for one cycle.
  - Otherwise on tick, cnt<=cnt+1.
  - Period length is (period_active+1) ticks.
  - period_active=0 gives a wrap on every tick.
- Compare: pwm_out[i] <= en_active[i] && (cnt < duty_active[i]).
  - Registered, so outputs lag cnt by 1 clk.
  - duty=0: constant low.
  - duty>period: constant high (100%).
  - Compare is unsigned, CNT_W bits; no overflow is possible.
- Simultaneous write and wrap: the active load takes the pre-write shadow value. The new write lands in shadow and takes effect at the following wrap.
- ena=0:
  - psc and cnt hold their values.
  - pwm_out <= 0 and period_tick <= 0 on the next clk.
  - Active registers hold.
  - Re-asserting ena resumes from the held count.
- Reset mid-period: all state returns to reset values asynchronously. There is no partial-pulse completion.

Decomposition:
- Package pwm_bank_pkg holds:
  - register address localparams ADDR_PERIOD, ADDR_EN, ADDR_PSC as offsets from NUM_CH
  - reset constants
  - struct pwm_cfg_t {period, en, prescale}, which is shadowed and loaded as one unit
- Sub-module pwm_cmp_ch: a single channel. It holds the duty shadow/active register pair and the registered compare output.
- Instantiate pwm_cmp_ch NUM_CH times in a generate loop.
- The top of pwm_bank holds the prescaler, the counter, the shared cfg shadows and the address decode.

Test Plan:
- Reset then idle: after rst_n release with ena=1 and no writes, pwm_out=0. period_tick pulses every 256 clks and cnt runs 0..255.
- Basic duty:
  - Stimulus: write period=9, duty0=3, en=0x01, psc=0.
  - Required: after the first wrap, ch0 is high 3 clks and low 7 clks, repeating every 10 clks. Other channels stay 0.
- Double-buffer:
  - Stimulus: with the basic-duty setup running, write duty0=7 at cnt=1.
  - Required: the current period keeps 3 high. The next period shows 7 high. No runt pulse.
- Boundaries:
  - Stimulus: ch1 duty=0, ch2 duty=10, ch3 duty=9 with period=9.
  - Required: ch1 constant 0, ch2 constant 1, ch3 high 9 and low 1.
- Prescale and ena:
  - Stimulus: psc=2 with the basic-duty setup. Then drop ena for 5 clks mid-period.
  - Required: while running, ch0 is high 9 clks per 30-clk period. During the ena-low window all outputs read 0 and cnt holds; the pattern then resumes.
- Write on the wrap cycle and bad address:
  - Stimulus: write period=4 exactly when period_tick asserts, and write address NUM_CH+3.
  - Required: the old period persists for one more cycle of periods. The bad-address write changes nothing.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
// Shared register map offsets, reset constants and the shadowed configuration
// record for the pwm_bank multi-channel PWM generator.
package pwm_bank_pkg;

  // Widest counter the cfg record can carry; narrower banks use the low bits.
  localparam int PWM_MAX_W = 32;

  // Register offsets above the per-channel duty registers (0..NUM_CH-1).
  localparam int ADDR_PERIOD = 0;
  localparam int ADDR_EN     = 1;
  localparam int ADDR_PSC    = 2;

  localparam logic [PWM_MAX_W-1:0] RST_DUTY = '0;
  localparam logic [PWM_MAX_W-1:0] RST_EN   = '0;
  localparam logic [PWM_MAX_W-1:0] RST_PSC  = '0;

  typedef struct packed {
    logic [PWM_MAX_W-1:0] period;
    logic [PWM_MAX_W-1:0] en;
    logic [PWM_MAX_W-1:0] prescale;
  } pwm_cfg_t;

  // Reset record: full-scale period for a cnt_w-bit counter, all else zero.
  function automatic pwm_cfg_t cfg_reset(input int cnt_w);
    pwm_cfg_t c;
    c.period = '0;
    for (int b = 0; b < PWM_MAX_W; b++) begin
      c.period[b] = (b < cnt_w);
    end
    c.en       = RST_EN;
    c.prescale = RST_PSC;
    return c;
  endfunction

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM compare channel: double-buffered duty register and a registered
// compare against the shared period counter.
module pwm_cmp_ch
  import pwm_bank_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             duty_we,
  input  logic [CNT_W-1:0] duty_wdata,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_shadow;
  logic [CNT_W-1:0] duty_active;

  // load fires on the period wrap; the active copy takes the pre-write shadow
  // when a write lands on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= CNT_W'(RST_DUTY);
      duty_active <= CNT_W'(RST_DUTY);
      pwm         <= 1'b0;
    end else begin
      if (duty_we) begin
        duty_shadow <= duty_wdata;
      end
      if (load) begin
        duty_active <= duty_shadow;
      end
      pwm <= ena && en && (cnt < duty_active);
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM: shared prescaler and period counter, NUM_CH compare
// channels, all configuration shadowed and loaded together at the period wrap.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = $clog2(NUM_CH + 3)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick,
  output logic [CNT_W-1:0]  cnt_out
);

  if (NUM_CH < 1 || NUM_CH > CNT_W) begin : g_bad_num_ch
    $error("pwm_bank: NUM_CH must lie in 1..CNT_W");
  end
  if (CNT_W > PWM_MAX_W) begin : g_bad_cnt_w
    $error("pwm_bank: CNT_W exceeds PWM_MAX_W");
  end

  localparam pwm_cfg_t CFG_RST = cfg_reset(CNT_W);

  pwm_cfg_t          cfg_shadow;
  pwm_cfg_t          cfg_active;
  logic [CNT_W-1:0]  psc;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  period_act;
  logic [CNT_W-1:0]  psc_act;
  logic [NUM_CH-1:0] en_act;
  logic [NUM_CH-1:0] duty_we;
  logic              sel_period;
  logic              sel_en;
  logic              sel_psc;
  logic              tick;
  logic              wrap;
  logic              unused_cfg;

  assign period_act = cfg_active.period[CNT_W-1:0];
  assign psc_act    = cfg_active.prescale[CNT_W-1:0];
  assign en_act     = cfg_active.en[NUM_CH-1:0];
  assign unused_cfg = ^cfg_active;

  // wr_en is a one-cycle strobe with no back-pressure: every write is
  // accepted on the edge it is presented, whatever the state of ena.
  assign sel_period = wr_en && (wr_addr == ADDR_W'(NUM_CH + ADDR_PERIOD));
  assign sel_en     = wr_en && (wr_addr == ADDR_W'(NUM_CH + ADDR_EN));
  assign sel_psc    = wr_en && (wr_addr == ADDR_W'(NUM_CH + ADDR_PSC));

  assign tick = (psc == psc_act);
  assign wrap = ena && tick && (cnt == period_act);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_shadow <= CFG_RST;
    end else begin
      if (sel_period) begin
        cfg_shadow.period <= PWM_MAX_W'(wr_data);
      end
      if (sel_en) begin
        cfg_shadow.en <= PWM_MAX_W'(wr_data[NUM_CH-1:0]);
      end
      if (sel_psc) begin
        cfg_shadow.prescale <= PWM_MAX_W'(wr_data);
      end
    end
  end

  // With ena low the counters and active config simply hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc         <= '0;
      cnt         <= '0;
      cfg_active  <= CFG_RST;
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
      if (ena) begin
        if (tick) begin
          psc <= '0;
        end else begin
          psc <= psc + 1'b1;
        end
        if (wrap) begin
          cnt        <= '0;
          cfg_active <= cfg_shadow;
        end else if (tick) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign cnt_out = cnt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign duty_we[i] = wr_en && (wr_addr == ADDR_W'(i));

    pwm_cmp_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .duty_we    (duty_we[i]),
      .duty_wdata (wr_data),
      .load       (wrap),
      .en         (en_act[i]),
      .cnt        (cnt),
      .pwm        (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: a cycle-level reference model built from
// the register map and counter rules, plus per-scenario pulse-shape checks.
module tb_pwm_bank;

  localparam int NUM_CH = 8;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = $clog2(NUM_CH + 3);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  wr_data;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_tick;
  logic [CNT_W-1:0]  cnt_out;

  int checks = 0;
  int errors = 0;

  pwm_bank #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .cnt_out     (cnt_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_duty_sh [NUM_CH];
  int m_duty_act[NUM_CH];
  int m_period_sh, m_period_act, m_en_sh, m_en_act, m_psc_sh, m_psc_act;
  int m_psc, m_cnt;
  logic [NUM_CH-1:0] m_pwm;
  logic m_tick;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_duty_sh[i]  = 0;
      m_duty_act[i] = 0;
    end
    m_period_sh  = (1 << CNT_W) - 1;
    m_period_act = (1 << CNT_W) - 1;
    m_en_sh = 0; m_en_act = 0; m_psc_sh = 0; m_psc_act = 0;
    m_psc = 0; m_cnt = 0; m_pwm = '0; m_tick = 1'b0;
  endtask

  task automatic model_step(input bit en_i, input bit we, input int addr, input int data);
    bit tk, wr;
    tk = (m_psc == m_psc_act);
    wr = en_i && tk && (m_cnt == m_period_act);
    m_pwm = '0;
    if (en_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_pwm[i] = (((m_en_act >> i) & 1) != 0) && (m_cnt < m_duty_act[i]);
      end
    end
    m_tick = wr;
    if (en_i) begin
      m_psc = tk ? 0 : m_psc + 1;
      if (wr) m_cnt = 0;
      else if (tk) m_cnt = m_cnt + 1;
    end
    if (wr) begin
      for (int i = 0; i < NUM_CH; i++) m_duty_act[i] = m_duty_sh[i];
      m_period_act = m_period_sh;
      m_en_act     = m_en_sh;
      m_psc_act    = m_psc_sh;
    end
    if (we) begin
      if (addr < NUM_CH) m_duty_sh[addr] = data;
      else if (addr == NUM_CH) m_period_sh = data;
      else if (addr == NUM_CH + 1) m_en_sh = data & ((1 << NUM_CH) - 1);
      else if (addr == NUM_CH + 2) m_psc_sh = data;
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the next falling edge with the model
  // advanced over the rising edge in between.
  task automatic drive_cycle(input bit en_i, input bit we, input int addr, input int data);
    ena     = en_i;
    wr_en   = we;
    wr_addr = ADDR_W'(addr);
    wr_data = CNT_W'(data);
    @(posedge clk);
    model_step(en_i, we, addr, data);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    #3;
    checks++;
    if (pwm_out !== '0) begin errors++; $display("FAIL reset_pwm got %h want 0", pwm_out); end
    checks++;
    if (period_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", period_tick); end
    checks++;
    if (cnt_out !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    int n_tick = 0, first = 0, second = 0, max_cnt = 0;
    for (int k = 1; k <= 600; k++) begin
      drive_cycle(1, 0, 0, 0);
      checks++;
      if (pwm_out !== m_pwm || period_tick !== m_tick || cnt_out !== CNT_W'(m_cnt)) begin
        errors++;
        $display("FAIL idle cyc %0d pwm %h tick %b cnt %0d want pwm %h tick %b cnt %0d",
                 k, pwm_out, period_tick, cnt_out, m_pwm, m_tick, m_cnt);
      end
      if (int'(cnt_out) > max_cnt) max_cnt = int'(cnt_out);
      if (period_tick === 1'b1) begin
        n_tick++;
        if (n_tick == 1) first = k;
        else if (n_tick == 2) second = k;
      end
    end
    checks++;
    if (n_tick != 2) begin errors++; $display("FAIL idle_tick_count got %0d want 2", n_tick); end
    checks++;
    if (first != 256) begin errors++; $display("FAIL idle_first_tick got %0d want 256", first); end
    checks++;
    if (second - first != 256) begin errors++; $display("FAIL idle_tick_gap got %0d want 256", second - first); end
    checks++;
    if (max_cnt != 255) begin errors++; $display("FAIL idle_cnt_max got %0d want 255", max_cnt); end
  endtask

  task automatic test_basic_duty();
    int wa[4];
    int wd[4];
    int ticks = 0, n = 0, hi0 = 0, hi_oth = 0, run = 0, max_run = 0;
    wa = '{NUM_CH, 0, NUM_CH + 1, NUM_CH + 2};
    wd = '{9, 3, 1, 0};
    for (int k = 0; k < 400 && ticks < 4; k++) begin
      if (k < 4) drive_cycle(1, 1, wa[k], wd[k]);
      else drive_cycle(1, 0, 0, 0);
      checks++;
      if (pwm_out !== m_pwm || period_tick !== m_tick || cnt_out !== CNT_W'(m_cnt)) begin
        errors++;
        $display("FAIL basic cyc %0d pwm %h tick %b cnt %0d want pwm %h tick %b cnt %0d",
                 k, pwm_out, period_tick, cnt_out, m_pwm, m_tick, m_cnt);
      end
      if (ticks >= 1) begin
        n++;
        hi0 += int'(pwm_out[0]);
        if (pwm_out[NUM_CH-1:1] !== '0) hi_oth++;
        run = (pwm_out[0] === 1'b1) ? run + 1 : 0;
        if (run > max_run) max_run = run;
      end
      if (period_tick === 1'b1) ticks++;
    end
    checks++;
    if (n != 30) begin errors++; $display("FAIL basic_span got %0d want 30", n); end
    checks++;
    if (hi0 != 9) begin errors++; $display("FAIL basic_ch0_high got %0d want 9", hi0); end
    checks++;
    if (hi_oth != 0) begin errors++; $display("FAIL basic_others got %0d want 0", hi_oth); end
    checks++;
    if (max_run != 3) begin errors++; $display("FAIL basic_run got %0d want 3", max_run); end
  endtask

  task automatic test_double_buffer();
    int idx = 0, rises = 0;
    int hi[2];
    logic prev;
    hi = '{0, 0};
    prev = pwm_out[0];
    for (int k = 0; k < 100 && idx < 2; k++) begin
      if (k == 1) drive_cycle(1, 1, 0, 7);
      else drive_cycle(1, 0, 0, 0);
      checks++;
      if (pwm_out !== m_pwm || period_tick !== m_tick || cnt_out !== CNT_W'(m_cnt)) begin
        errors++;
        $display("FAIL dbuf cyc %0d pwm %h tick %b cnt %0d want pwm %h tick %b cnt %0d",
                 k, pwm_out, period_tick, cnt_out, m_pwm, m_tick, m_cnt);
      end
      hi[idx] += int'(pwm_out[0]);
      if (pwm_out[0] === 1'b1 && prev !== 1'b1) rises++;
      prev = pwm_out[0];
      if (period_tick === 1'b1) idx++;
    end
    checks++;
    if (hi[0] != 3) begin errors++; $display("FAIL dbuf_current got %0d want 3", hi[0]); end
    checks++;
    if (hi[1] != 7) begin errors++; $display("FAIL dbuf_next got %0d want 7", hi[1]); end
    checks++;
    if (rises != 2) begin errors++; $display("FAIL dbuf_pulses got %0d want 2", rises); end
  endtask

  task automatic test_boundaries();
    int wa[4];
    int wd[4];
    int idx = 0;
    int hi[2][4];
    int want[4];
    wa = '{1, 2, 3, NUM_CH + 1};
    wd = '{0, 10, 9, 'h0F};
    want = '{7, 0, 10, 9};
    for (int p = 0; p < 2; p++) for (int c = 0; c < 4; c++) hi[p][c] = 0;
    for (int k = 0; k < 100 && idx < 2; k++) begin
      if (k < 4) drive_cycle(1, 1, wa[k], wd[k]);
      else drive_cycle(1, 0, 0, 0);
      checks++;
      if (pwm_out !== m_pwm || period_tick !== m_tick || cnt_out !== CNT_W'(m_cnt)) begin
        errors++;
        $display("FAIL bound cyc %0d pwm %h tick %b cnt %0d want pwm %h tick %b cnt %0d",
                 k, pwm_out, period_tick, cnt_out, m_pwm, m_tick, m_cnt);
      end
      for (int c = 0; c < 4; c++) hi[idx][c] += int'(pwm_out[c]);
      if (period_tick === 1'b1) idx++;
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (hi[1][c] != want[c]) begin
        errors++;
        $display("FAIL bound_ch%0d high got %0d want %0d", c, hi[1][c], want[c]);
      end
    end
  endtask

  task automatic test_prescale_ena();
    int ph = 0, n = 0, hi0 = 0, hi4 = 0, held = 0, dwell = 0;
    for (int k = 0; k < 600 && ph < 6; k++) begin
      if (k == 0) drive_cycle(1, 1, 0, 3);
      else if (k == 1) drive_cycle(1, 1, NUM_CH + 2, 2);
      else if (ph == 3) begin
        dwell++;
        if (dwell == 2) drive_cycle(0, 1, 4, 5);
        else if (dwell == 3) drive_cycle(0, 1, NUM_CH + 1, 'h1F);
        else drive_cycle(0, 0, 0, 0);
      end else drive_cycle(1, 0, 0, 0);
      checks++;
      if (pwm_out !== m_pwm || period_tick !== m_tick || cnt_out !== CNT_W'(m_cnt)) begin
        errors++;
        $display("FAIL psc cyc %0d pwm %h tick %b cnt %0d want pwm %h tick %b cnt %0d",
                 k, pwm_out, period_tick, cnt_out, m_pwm, m_tick, m_cnt);
      end
      if (ph == 1 || ph == 5) begin
        n++;
        hi0 += int'(pwm_out[0]);
        hi4 += int'(pwm_out[4]);
      end
      if (ph == 3) begin
        checks++;
        if (pwm_out !== '0 || period_tick !== 1'b0 || cnt_out !== CNT_W'(held)) begin
          errors++;
          $display("FAIL ena_low dwell %0d pwm %h tick %b cnt %0d want pwm 0 tick 0 cnt %0d",
                   dwell, pwm_out, period_tick, cnt_out, held);
        end
      end
      if (ph == 0 && period_tick === 1'b1) ph = 1;
      else if (ph == 1 && period_tick === 1'b1) begin
        checks++;
        if (n != 30) begin errors++; $display("FAIL psc_span got %0d want 30", n); end
        checks++;
        if (hi0 != 9) begin errors++; $display("FAIL psc_ch0_high got %0d want 9", hi0); end
        ph = 2;
      end else if (ph == 2 && m_cnt == 4) begin
        held = m_cnt;
        ph = 3;
      end else if (ph == 3 && dwell == 5) ph = 4;
      else if (ph == 4 && period_tick === 1'b1) begin
        n = 0; hi0 = 0; hi4 = 0;
        ph = 5;
      end else if (ph == 5 && period_tick === 1'b1) begin
        checks++;
        if (n != 30) begin errors++; $display("FAIL resume_span got %0d want 30", n); end
        checks++;
        if (hi0 != 9) begin errors++; $display("FAIL resume_ch0_high got %0d want 9", hi0); end
        checks++;
        if (hi4 != 15) begin errors++; $display("FAIL resume_ch4_high got %0d want 15", hi4); end
        ph = 6;
      end
    end
    checks++;
    if (ph != 6) begin errors++; $display("FAIL psc_timeout got phase %0d want 6", ph); end
  endtask

  task automatic test_wrap_write();
    int ph = 0, n = 0, iv0 = 0, iv1 = 0, hi0 = 0, hi2 = 0, hi3 = 0;
    int max_addr;
    bit just;
    max_addr = (1 << ADDR_W) - 1;
    for (int k = 0; k < 400 && ph < 4; k++) begin
      just = 1'b0;
      if (k == 0) drive_cycle(1, 1, NUM_CH + 2, 0);
      else if (ph == 1 && m_cnt == 9 && m_psc == m_psc_act) begin
        drive_cycle(1, 1, NUM_CH, 4);
        just = 1'b1;
      end else if (ph == 2 && n == 2) drive_cycle(1, 1, NUM_CH + 3, $urandom_range(0, 255));
      else if (ph == 2 && n == 4) drive_cycle(1, 1, $urandom_range(NUM_CH + 3, max_addr), $urandom_range(0, 255));
      else drive_cycle(1, 0, 0, 0);
      checks++;
      if (pwm_out !== m_pwm || period_tick !== m_tick || cnt_out !== CNT_W'(m_cnt)) begin
        errors++;
        $display("FAIL wrapwr cyc %0d pwm %h tick %b cnt %0d want pwm %h tick %b cnt %0d",
                 k, pwm_out, period_tick, cnt_out, m_pwm, m_tick, m_cnt);
      end
      if (just) begin
        checks++;
        if (period_tick !== 1'b1) begin errors++; $display("FAIL wrapwr_tick got %b want 1", period_tick); end
        n = 0;
        ph = 2;
      end else if (ph == 0) begin
        if (period_tick === 1'b1) ph = 1;
      end else if (ph == 2) begin
        n++;
        if (period_tick === 1'b1) begin iv0 = n; n = 0; ph = 3; end
      end else if (ph == 3) begin
        n++;
        hi0 += int'(pwm_out[0]);
        hi2 += int'(pwm_out[2]);
        hi3 += int'(pwm_out[3]);
        if (period_tick === 1'b1) begin iv1 = n; ph = 4; end
      end
    end
    checks++;
    if (ph != 4) begin errors++; $display("FAIL wrapwr_timeout got phase %0d want 4", ph); end
    checks++;
    if (iv0 != 10) begin errors++; $display("FAIL wrapwr_old_period got %0d want 10", iv0); end
    checks++;
    if (iv1 != 5) begin errors++; $display("FAIL wrapwr_new_period got %0d want 5", iv1); end
    checks++;
    if (hi0 != 3 || hi2 != 5 || hi3 != 5) begin
      errors++;
      $display("FAIL wrapwr_highs got %0d/%0d/%0d want 3/5/5", hi0, hi2, hi3);
    end
  endtask

  task automatic test_random();
    bit en_i, we;
    int addr, data;
    for (int k = 0; k < 1500; k++) begin
      en_i = ($urandom_range(0, 9) != 0);
      we   = ($urandom_range(0, 3) == 0);
      addr = $urandom_range(0, (1 << ADDR_W) - 1);
      data = $urandom_range(0, 255);
      if (addr == NUM_CH || addr == NUM_CH + 2) data = $urandom_range(0, 6);
      else if (addr < NUM_CH) data = $urandom_range(0, 9);
      drive_cycle(en_i, we, addr, data);
      checks++;
      if (pwm_out !== m_pwm || period_tick !== m_tick || cnt_out !== CNT_W'(m_cnt)) begin
        errors++;
        $display("FAIL random cyc %0d pwm %h tick %b cnt %0d want pwm %h tick %b cnt %0d",
                 k, pwm_out, period_tick, cnt_out, m_pwm, m_tick, m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== '0 || period_tick !== 1'b0 || cnt_out !== '0) begin
      errors++;
      $display("FAIL reset_mid pwm %h tick %b cnt %0d want pwm 0 tick 0 cnt 0", pwm_out, period_tick, cnt_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      drive_cycle(1, 0, 0, 0);
      checks++;
      if (pwm_out !== m_pwm || period_tick !== m_tick || cnt_out !== CNT_W'(m_cnt)) begin
        errors++;
        $display("FAIL post_reset cyc %0d pwm %h tick %b cnt %0d want pwm %h tick %b cnt %0d",
                 k, pwm_out, period_tick, cnt_out, m_pwm, m_tick, m_cnt);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_basic_duty();
    test_double_buffer();
    test_boundaries();
    test_prescale_ena();
    test_wrap_write();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
